prt_dp_lb_mbox: RTL and testbench

Local-bus responder mailbox between the application CPU and a streaming agent elsewhere in the design. An inbound 32-bit stream fills an RX FIFO that the CPU drains by register reads. CPU register writes fill a TX FIFO that drains to an outbound valid/ready stream. It attaches to one downstream port of the local-bus mux and raises a level interrupt toward the CPU interrupt OR.

---
 rtl/prt_dp_lb_mbox_if.sv | 28 ++
 rtl/prt_dp_lb_mbox.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_prt_dp_lb_mbox.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prt_dp_lb_mbox_if.sv
// -----------------------------------------------------------------------------
// prt_dp_lb_if
// Local-bus connection between the local-bus mux and one responder.
//   adr  : register address (responders decode the low bits they need)
//   wr   : single-cycle write strobe, din carries the write data
//   rd   : single-cycle read strobe
//   din  : write data
//   dout : read data, valid only while vld is high (0 otherwise)
//   vld  : one-cycle read response strobe
// Modports:
//   lb_in  : responder side (mailbox, peripherals)
//   lb_out : requester side (mux downstream port)
// -----------------------------------------------------------------------------
interface prt_dp_lb_if #(
   parameter int P_ADR_WIDTH = 16
) ();

   logic [P_ADR_WIDTH-1:0] adr;
   logic                   wr;
   logic                   rd;
   logic [31:0]            din;
   logic [31:0]            dout;
   logic                   vld;

   modport lb_in  (input adr, input wr, input rd, input din, output dout, output vld);
   modport lb_out (output adr, output wr, output rd, output din, input dout, input vld);

endinterface

// File: rtl/prt_dp_lb_mbox.sv
// -----------------------------------------------------------------------------
// prt_dp_lb_mbox
// Local-bus responder mailbox between the application CPU and a streaming
// agent. Inbound stream words fill an RX FIFO that the CPU drains through
// RXDAT reads; CPU writes to TXDAT fill a TX FIFO that drains to the outbound
// valid/ready stream. A level interrupt reports pending RX data and errors.
//
// Register map (adr[1:0], upper address bits ignored):
//   0 CTL   R/W  [0] RUN, [1] IRQ_EN, [2] FLUSH (pulse, reads 0)
//   1 STA   R/W1C [0] RX empty [1] RX full [2] RX underflow (W1C)
//                 [3] TX empty [4] TX full [5] TX overflow (W1C)
//                 [15:8] RX count [23:16] TX count
//   2 RXDAT RO   read pops RX head; empty read returns 0 and flags underflow
//   3 TXDAT WO   write pushes TX; write while full is dropped, flags overflow
//
// Ports:
//   CLK_IN       system clock
//   RST_IN       asynchronous active-low reset
//   LB_IF        local-bus responder port (prt_dp_lb_if.lb_in)
//   SRC_DAT_IN   inbound stream data
//   SRC_VLD_IN   inbound stream valid
//   SRC_RDY_OUT  inbound stream ready
//   SNK_DAT_OUT  outbound stream data (TX head)
//   SNK_VLD_OUT  outbound stream valid
//   SNK_RDY_IN   outbound stream ready
//   IRQ_OUT      level interrupt, registered
// -----------------------------------------------------------------------------
module prt_dp_lb_mbox #(
   parameter int P_FIFO_DEPTH = 16,
   parameter int P_ADR_WIDTH  = 16
) (
   input  logic        CLK_IN,
   input  logic        RST_IN,
   prt_dp_lb_if.lb_in  LB_IF,
   input  logic [31:0] SRC_DAT_IN,
   input  logic        SRC_VLD_IN,
   output logic        SRC_RDY_OUT,
   output logic [31:0] SNK_DAT_OUT,
   output logic        SNK_VLD_OUT,
   input  logic        SNK_RDY_IN,
   output logic        IRQ_OUT
);

   localparam int AW = $clog2(P_FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] C_CNT_FULL = CW'(P_FIFO_DEPTH);
   localparam logic [CW-1:0] C_CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] C_PTR_ZERO = AW'(0);
   localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

   localparam logic [1:0] C_REG_CTL = 2'd0;
   localparam logic [1:0] C_REG_STA = 2'd1;
   localparam logic [1:0] C_REG_RXD = 2'd2;
   localparam logic [1:0] C_REG_TXD = 2'd3;

   // Occupancy count update for one FIFO given this cycle's push/pop.
   function automatic logic [CW-1:0] f_cnt_next(input logic [CW-1:0] cnt,
                                                 input logic          push,
                                                 input logic          pop);
      logic [CW-1:0] res;
      case ({push, pop})
         2'b10:   res = cnt + C_CNT_ONE;
         2'b01:   res = cnt - C_CNT_ONE;
         default: res = cnt;
      endcase
      return res;
   endfunction

   // Pointer advance; depth is a power of two so the natural wrap is modulo depth.
   function automatic logic [AW-1:0] f_ptr_next(input logic [AW-1:0] ptr,
                                                 input logic          adv);
      logic [AW-1:0] res;
      if (adv) begin
         res = ptr + C_PTR_ONE;
      end else begin
         res = ptr;
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]   rx_mem_q [P_FIFO_DEPTH];
   logic [31:0]   tx_mem_q [P_FIFO_DEPTH];

   logic          run_q,     run_d;
   logic          irq_en_q,  irq_en_d;
   logic [AW-1:0] rx_wp_q,   rx_wp_d;
   logic [AW-1:0] rx_rp_q,   rx_rp_d;
   logic [CW-1:0] rx_cnt_q,  rx_cnt_d;
   logic [AW-1:0] tx_wp_q,   tx_wp_d;
   logic [AW-1:0] tx_rp_q,   tx_rp_d;
   logic [CW-1:0] tx_cnt_q,  tx_cnt_d;
   logic          rx_unf_q,  rx_unf_d;
   logic          tx_ovf_q,  tx_ovf_d;
   logic          lb_vld_q,  lb_vld_d;
   logic [31:0]   lb_dout_q, lb_dout_d;
   logic          irq_q,     irq_d;

   // ---------------------------------------------------------------------------
   // Decode and status
   // ---------------------------------------------------------------------------
   logic [1:0]  reg_sel_s;
   logic        wr_s;
   logic        rd_s;
   logic        ctl_wr_s;
   logic        sta_wr_s;
   logic        flush_s;
   logic        rx_pop_req_s;
   logic        tx_push_req_s;
   logic        rx_empty_s;
   logic        rx_full_s;
   logic        tx_empty_s;
   logic        tx_full_s;
   logic        src_rdy_s;
   logic        snk_vld_s;
   logic        rx_push_s;
   logic        rx_pop_s;
   logic        tx_push_s;
   logic        tx_pop_s;
   logic [7:0]  rx_cnt8_s;
   logic [7:0]  tx_cnt8_s;
   logic [31:0] sta_s;
   logic [31:0] rd_data_s;
   logic        unused_adr_s;

   assign reg_sel_s    = LB_IF.adr[1:0];
   assign unused_adr_s = ^LB_IF.adr[P_ADR_WIDTH-1:2];

   // A write strobe always wins over a simultaneous read strobe.
   assign wr_s = LB_IF.wr;
   assign rd_s = LB_IF.rd & ~LB_IF.wr;

   assign ctl_wr_s      = wr_s & (reg_sel_s == C_REG_CTL);
   assign sta_wr_s      = wr_s & (reg_sel_s == C_REG_STA);
   assign flush_s       = ctl_wr_s & LB_IF.din[2];
   assign rx_pop_req_s  = rd_s & (reg_sel_s == C_REG_RXD);
   assign tx_push_req_s = wr_s & (reg_sel_s == C_REG_TXD);

   assign rx_empty_s = (rx_cnt_q == C_CNT_ZERO);
   assign rx_full_s  = (rx_cnt_q == C_CNT_FULL);
   assign tx_empty_s = (tx_cnt_q == C_CNT_ZERO);
   assign tx_full_s  = (tx_cnt_q == C_CNT_FULL);

   // Stream handshakes depend only on registered state, never on the peer.
   assign src_rdy_s = run_q & ~rx_full_s;
   assign snk_vld_s = run_q & ~tx_empty_s;

   // FLUSH suppresses every FIFO movement in its cycle.
   assign rx_push_s = SRC_VLD_IN & src_rdy_s & ~flush_s;
   assign rx_pop_s  = rx_pop_req_s & ~rx_empty_s & ~flush_s;
   assign tx_push_s = tx_push_req_s & ~tx_full_s & ~flush_s;
   assign tx_pop_s  = snk_vld_s & SNK_RDY_IN & ~flush_s;

   assign rx_cnt8_s = 8'(rx_cnt_q);
   assign tx_cnt8_s = 8'(tx_cnt_q);

   assign sta_s = {8'h00, tx_cnt8_s, rx_cnt8_s, 2'b00,
                   tx_ovf_q, tx_full_s, tx_empty_s,
                   rx_unf_q, rx_full_s, rx_empty_s};

   // Read-data mux; every value reflects state before this cycle's updates.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (reg_sel_s)
         C_REG_CTL: rd_data_s = {30'h0000_0000, irq_en_q, run_q};
         C_REG_STA: rd_data_s = sta_s;
         C_REG_RXD: begin
            if (!rx_empty_s) begin
               rd_data_s = rx_mem_q[rx_rp_q];
            end else begin
               rd_data_s = 32'h0000_0000;
            end
         end
         default:   rd_data_s = 32'h0000_0000;
      endcase
   end

   // Next-state computation for control, FIFO bookkeeping, flags and outputs.
   always_comb begin
      run_d     = run_q;
      irq_en_d  = irq_en_q;
      rx_wp_d   = rx_wp_q;
      rx_rp_d   = rx_rp_q;
      rx_cnt_d  = rx_cnt_q;
      tx_wp_d   = tx_wp_q;
      tx_rp_d   = tx_rp_q;
      tx_cnt_d  = tx_cnt_q;
      rx_unf_d  = rx_unf_q;
      tx_ovf_d  = tx_ovf_q;
      lb_vld_d  = 1'b0;
      lb_dout_d = 32'h0000_0000;
      irq_d     = 1'b0;

      if (ctl_wr_s) begin
         run_d    = LB_IF.din[0];
         irq_en_d = LB_IF.din[1];
      end else begin
         run_d    = run_q;
         irq_en_d = irq_en_q;
      end

      if (flush_s) begin
         rx_wp_d  = C_PTR_ZERO;
         rx_rp_d  = C_PTR_ZERO;
         rx_cnt_d = C_CNT_ZERO;
         tx_wp_d  = C_PTR_ZERO;
         tx_rp_d  = C_PTR_ZERO;
         tx_cnt_d = C_CNT_ZERO;
         rx_unf_d = 1'b0;
         tx_ovf_d = 1'b0;
      end else begin
         rx_wp_d  = f_ptr_next(rx_wp_q, rx_push_s);
         rx_rp_d  = f_ptr_next(rx_rp_q, rx_pop_s);
         rx_cnt_d = f_cnt_next(rx_cnt_q, rx_push_s, rx_pop_s);
         tx_wp_d  = f_ptr_next(tx_wp_q, tx_push_s);
         tx_rp_d  = f_ptr_next(tx_rp_q, tx_pop_s);
         tx_cnt_d = f_cnt_next(tx_cnt_q, tx_push_s, tx_pop_s);
         // Sticky flags: set on the error event, cleared by writing 1 to STA.
         rx_unf_d = (rx_unf_q & ~(sta_wr_s & LB_IF.din[2])) | (rx_pop_req_s & rx_empty_s);
         tx_ovf_d = (tx_ovf_q & ~(sta_wr_s & LB_IF.din[5])) | (tx_push_req_s & tx_full_s);
      end

      if (rd_s) begin
         lb_vld_d  = 1'b1;
         lb_dout_d = rd_data_s;
      end else begin
         lb_vld_d  = 1'b0;
         lb_dout_d = 32'h0000_0000;
      end

      irq_d = irq_en_q & (~rx_empty_s | rx_unf_q | tx_ovf_q);
   end

   // Control/status registers with asynchronous reset.
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         run_q     <= 1'b0;
         irq_en_q  <= 1'b0;
         rx_wp_q   <= C_PTR_ZERO;
         rx_rp_q   <= C_PTR_ZERO;
         rx_cnt_q  <= C_CNT_ZERO;
         tx_wp_q   <= C_PTR_ZERO;
         tx_rp_q   <= C_PTR_ZERO;
         tx_cnt_q  <= C_CNT_ZERO;
         rx_unf_q  <= 1'b0;
         tx_ovf_q  <= 1'b0;
         lb_vld_q  <= 1'b0;
         lb_dout_q <= 32'h0000_0000;
         irq_q     <= 1'b0;
      end else begin
         run_q     <= run_d;
         irq_en_q  <= irq_en_d;
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_wp_q   <= tx_wp_d;
         tx_rp_q   <= tx_rp_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_unf_q  <= rx_unf_d;
         tx_ovf_q  <= tx_ovf_d;
         lb_vld_q  <= lb_vld_d;
         lb_dout_q <= lb_dout_d;
         irq_q     <= irq_d;
      end
   end

   // FIFO storage; no reset so it maps onto distributed RAM. Contents are only
   // observed through the counts, so stale words are never visible.
   always_ff @(posedge CLK_IN) begin
      if (rx_push_s) begin
         rx_mem_q[rx_wp_q] <= SRC_DAT_IN;
      end
      if (tx_push_s) begin
         tx_mem_q[tx_wp_q] <= LB_IF.din;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign LB_IF.vld   = lb_vld_q;
   assign LB_IF.dout  = lb_dout_q;
   assign SRC_RDY_OUT = src_rdy_s;
   assign SNK_VLD_OUT = snk_vld_s;
   // Head is read asynchronously so the first word needs no read-ahead cycle;
   // it is forced to 0 while not valid so reset and idle show a clean bus.
   assign SNK_DAT_OUT = snk_vld_s ? tx_mem_q[tx_rp_q] : 32'h0000_0000;
   assign IRQ_OUT     = irq_q;

endmodule

// File: tb/tb_prt_dp_lb_mbox.sv
// Scoreboard bench for prt_dp_lb_mbox: stimulus pushes expected responses
// into queues, a negedge monitor pops and compares whenever the DUT presents
// a local-bus read response or an outbound stream transfer.
module tb_prt_dp_lb_mbox;

   localparam int P_FIFO_DEPTH = 16;
   localparam int P_ADR_WIDTH  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] src_dat;
   logic        src_vld;
   logic        src_rdy;
   logic [31:0] snk_dat;
   logic        snk_vld;
   logic        snk_rdy;
   logic        irq;

   prt_dp_lb_if #(.P_ADR_WIDTH(P_ADR_WIDTH)) lb_if ();

   prt_dp_lb_mbox #(
      .P_FIFO_DEPTH(P_FIFO_DEPTH),
      .P_ADR_WIDTH (P_ADR_WIDTH)
   ) dut (
      .CLK_IN     (clk),
      .RST_IN     (rst_n),
      .LB_IF      (lb_if),
      .SRC_DAT_IN (src_dat),
      .SRC_VLD_IN (src_vld),
      .SRC_RDY_OUT(src_rdy),
      .SNK_DAT_OUT(snk_dat),
      .SNK_VLD_OUT(snk_vld),
      .SNK_RDY_IN (snk_rdy),
      .IRQ_OUT    (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int unsigned due;
   } rd_exp_t;

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc_cnt = 0;
   rd_exp_t     lb_exp_q[$];
   logic [31:0] snk_exp_q[$];
   rd_exp_t     mon_e;
   logic [31:0] mon_s;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare read responses and sink transfers against the queues.
   always @(negedge clk) begin
      if (lb_if.vld === 1'b1) begin
         if (lb_exp_q.size() == 0) begin
            chk("lb_spurious_vld", {31'h0, lb_if.vld}, 32'h0);
         end else begin
            mon_e = lb_exp_q.pop_front();
            chk("lb_rd_data", lb_if.dout, mon_e.data);
            chk("lb_rd_cycle", cyc_cnt, mon_e.due);
         end
      end else begin
         chk("lb_idle_dout", lb_if.dout, 32'h0);
      end
      if (snk_vld === 1'b1 && snk_rdy === 1'b1) begin
         if (snk_exp_q.size() == 0) begin
            chk("snk_spurious_word", snk_dat, 32'hFFFF_FFFF);
         end else begin
            mon_s = snk_exp_q.pop_front();
            chk("snk_data", snk_dat, mon_s);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic lb_wr(input logic [1:0] a, input logic [31:0] d);
      lb_if.adr = {14'h0B2D, a};
      lb_if.din = d;
      lb_if.wr  = 1'b1;
      cyc();
      lb_if.wr  = 1'b0;
   endtask

   task automatic lb_rd(input logic [1:0] a, input logic [31:0] exp);
      rd_exp_t e;
      e.data = exp;
      e.due  = cyc_cnt + 1;
      lb_exp_q.push_back(e);
      lb_if.adr = {14'h0B2D, a};
      lb_if.rd  = 1'b1;
      cyc();
      lb_if.rd  = 1'b0;
   endtask

   task automatic src_push(input logic [31:0] d);
      src_dat = d;
      src_vld = 1'b1;
      cyc();
      src_vld = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((lb_exp_q.size() != 0 || snk_exp_q.size() != 0) && n < 100) begin
         cyc();
         n++;
      end
      chk(name, 32'(lb_exp_q.size() + snk_exp_q.size()), 32'h0);
   endtask

   initial begin
      rst_n      = 1'b0;
      src_dat    = 32'h0;
      src_vld    = 1'b1;
      snk_rdy    = 1'b1;
      lb_if.adr  = 16'h0;
      lb_if.wr   = 1'b0;
      lb_if.rd   = 1'b0;
      lb_if.din  = 32'h0;

      // ---- reset with both stream peers pushing/accepting ----
      repeat (3) cyc();
      chk("rst_src_rdy", {31'h0, src_rdy}, 32'h0);
      chk("rst_snk_vld", {31'h0, snk_vld}, 32'h0);
      chk("rst_snk_dat", snk_dat, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rst_n = 1'b1;
      cyc();
      chk("idle_src_rdy", {31'h0, src_rdy}, 32'h0);
      lb_rd(2'd1, 32'h0000_0009);
      src_vld = 1'b0;
      drain("drain_reset");

      // ---- RX fill to full, then drain past empty ----
      lb_wr(2'd0, 32'h1);
      for (int i = 0; i < 16; i++) begin
         chk("rx_src_rdy_open", {31'h0, src_rdy}, 32'h1);
         src_push(32'h100 + 32'(i));
      end
      chk("rx_src_rdy_full", {31'h0, src_rdy}, 32'h0);
      // count 16, RX full, TX still empty
      lb_rd(2'd1, 32'h0000_100A);
      for (int i = 0; i < 16; i++) lb_rd(2'd2, 32'h100 + 32'(i));
      lb_rd(2'd2, 32'h0);
      lb_rd(2'd1, 32'h0000_000D);
      lb_wr(2'd1, 32'h4);
      lb_rd(2'd1, 32'h0000_0009);
      drain("drain_rx");

      // ---- TX fill with overflow, then drain to sink ----
      snk_rdy = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) snk_exp_q.push_back(32'hA0 + 32'(i));
         lb_wr(2'd3, 32'hA0 + 32'(i));
      end
      chk("tx_stall_vld", {31'h0, snk_vld}, 32'h1);
      chk("tx_stall_dat", snk_dat, 32'hA0);
      lb_rd(2'd1, 32'h0010_0031);
      cyc();
      chk("tx_stall_dat_hold", snk_dat, 32'hA0);
      snk_rdy = 1'b1;
      drain("drain_tx");
      repeat (3) cyc();
      chk("tx_empty_vld", {31'h0, snk_vld}, 32'h0);
      lb_wr(2'd1, 32'h20);
      lb_rd(2'd1, 32'h0000_0009);
      drain("drain_tx_sta");

      // ---- interrupt behaviour ----
      lb_wr(2'd0, 32'h3);
      chk("irq_idle", {31'h0, irq}, 32'h0);
      src_push(32'h55);
      chk("irq_push_lag", {31'h0, irq}, 32'h0);
      cyc();
      chk("irq_rx_rise", {31'h0, irq}, 32'h1);
      lb_rd(2'd2, 32'h55);
      chk("irq_pop_lag", {31'h0, irq}, 32'h1);
      cyc();
      chk("irq_pop_fall", {31'h0, irq}, 32'h0);
      lb_rd(2'd2, 32'h0);
      chk("irq_unf_lag", {31'h0, irq}, 32'h0);
      cyc();
      chk("irq_unf_rise", {31'h0, irq}, 32'h1);
      lb_wr(2'd1, 32'h4);
      chk("irq_w1c_lag", {31'h0, irq}, 32'h1);
      cyc();
      chk("irq_w1c_fall", {31'h0, irq}, 32'h0);
      drain("drain_irq");

      // ---- clearing RUN stalls both streams but keeps contents ----
      lb_wr(2'd0, 32'h1);
      snk_rdy = 1'b0;
      lb_wr(2'd3, 32'h77);
      chk("run_snk_vld", {31'h0, snk_vld}, 32'h1);
      chk("run_snk_dat", snk_dat, 32'h77);
      lb_wr(2'd0, 32'h0);
      chk("stop_snk_vld", {31'h0, snk_vld}, 32'h0);
      chk("stop_src_rdy", {31'h0, src_rdy}, 32'h0);
      snk_rdy = 1'b1;
      src_dat = 32'hDEAD;
      src_vld = 1'b1;
      repeat (3) cyc();
      src_vld = 1'b0;
      lb_rd(2'd1, 32'h0001_0001);
      drain("drain_stop");
      snk_exp_q.push_back(32'h77);
      lb_wr(2'd0, 32'h1);
      drain("drain_restart");
      lb_rd(2'd1, 32'h0000_0009);

      // ---- FLUSH with a concurrent source push ----
      snk_rdy = 1'b0;
      lb_rd(2'd2, 32'h0);
      for (int i = 0; i < 5; i++) src_push(32'h200 + 32'(i));
      for (int i = 0; i < 5; i++) lb_wr(2'd3, 32'h300 + 32'(i));
      lb_rd(2'd1, 32'h0005_0504);
      src_dat = 32'h999;
      src_vld = 1'b1;
      lb_wr(2'd0, 32'h5);
      src_vld = 1'b0;
      lb_rd(2'd1, 32'h0000_0009);
      lb_rd(2'd0, 32'h0000_0001);
      snk_rdy = 1'b1;
      repeat (4) cyc();
      drain("drain_flush");

      // ---- back-to-back reads of STA, RXDAT, CTL ----
      src_push(32'h4242);
      cyc();
      lb_rd(2'd1, 32'h0000_0108);
      lb_rd(2'd2, 32'h4242);
      lb_rd(2'd0, 32'h0000_0001);
      repeat (3) cyc();
      drain("drain_b2b");

      // ---- wr and rd together: write wins, no response ----
      snk_exp_q.push_back(32'h5A);
      lb_if.adr = {14'h0B2D, 2'd3};
      lb_if.din = 32'h5A;
      lb_if.wr  = 1'b1;
      lb_if.rd  = 1'b1;
      cyc();
      lb_if.wr  = 1'b0;
      lb_if.rd  = 1'b0;
      repeat (3) cyc();
      drain("drain_wr_rd");

      // ---- asynchronous reset while a read response is on the bus ----
      snk_rdy = 1'b0;
      lb_wr(2'd3, 32'h1234);
      lb_if.adr = {14'h0B2D, 2'd1};
      lb_if.rd  = 1'b1;
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      lb_if.rd = 1'b0;
      #1;
      chk("async_rst_vld", {31'h0, lb_if.vld}, 32'h0);
      chk("async_rst_snk_vld", {31'h0, snk_vld}, 32'h0);
      chk("async_rst_src_rdy", {31'h0, src_rdy}, 32'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      lb_rd(2'd0, 32'h0);
      lb_rd(2'd1, 32'h0000_0009);
      repeat (2) cyc();
      drain("drain_final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
